sat_sample_gen: RTL
===================

Name: sat_sample_gen

Overview:
- Sequential producer that drives candidate assignments into a combinational constraint checker and emits only the satisfying ones.
- The checker consumes a flat variable vector and returns one satisfied bit. This block generates pseudo-random vectors and samples that bit.
- Accepted vectors are handed downstream over a valid/ready interface, with try and sample budgets.
- Sits between the solver/benchmark controller and the checker; serves as the random-sampling reference against BDD-based solving.

Parameters:
- VEC_W, 185, total candidate width. The default is the concatenation of the 10-variable problem: widths 16, 22, 4, 28, 19, 18, 19, 14, 16 and 29, with var_0 at the LSBs.
- RNG_W, 64, width of the xorshift state and bits injected per cycle; fixed at 64.
- FILL_CYC, ceil(VEC_W/RNG_W) = 3, warm-up shifts before the first check.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only when busy=0
- seed  in  64  RNG seed, latched on an accepted start
- max_tries  in  32  check budget; 0 = unlimited
- num_samples  in  16  samples to deliver; 0 = unlimited (continuous)
- cand  out  VEC_W  registered candidate driven to the checker
- sat_in  in  1  checker result; combinational function of cand only
- out_valid  out  1  out_data holds a satisfying vector
- out_ready  in  1  downstream accepts
- out_data  out  VEC_W  satisfying vector
- busy  out  1  run in progress
- done  out  1  sample quota met; level, held until the next start
- fail  out  1  try budget exhausted; level, held until the next start
- tries_used  out  32  SEARCH cycles consumed in the current run

Behaviour:
- Reset: state=IDLE. Outputs cand, out_data, out_valid, busy, done, fail and tries_used all go to 0. The RNG state is loaded with K=64'h9E3779B97F4A7C15. Reset applied in any state aborts the run and takes effect next cycle.
- RNG: xorshift64 with s^=s<<13, s^=s>>7, s^=s<<17. One step per advancing cycle. On each step, cand <= {cand[VEC_W-65:0], s_next}.
- Seeding: seed==0 loads K, so seed 0 and seed K produce identical streams.
- IDLE, start=1: latch seed, max_tries and num_samples. Set cand=0, tries_used=0, sample count=0, done=0, fail=0, busy=1. Go to FILL.
- start while busy=1 is ignored.
- FILL: the RNG advances for FILL_CYC cycles; sat_in is ignored. Then go to SEARCH.
- SEARCH, per cycle: the RNG advances and tries_used increments. sat_in is evaluated on the cand value present this cycle.
  - sat_in=1: out_data<=cand, out_valid<=1, sample count +1, go to HOLD. out_valid rises one cycle after the sat cycle.
  - sat_in=0 with max_tries!=0 and tries_used+1==max_tries: go to FAIL.
  - If both apply in the same cycle, sat_in wins. The sample is delivered, and FAIL is entered on the next SEARCH check if the budget is still exhausted.
- HOLD: RNG, cand and tries_used are frozen. out_valid and out_data stay stable until out_ready=1.
  - On out_valid&&out_ready: out_valid<=0. If num_samples!=0 and count==num_samples, go to DONE; otherwise go to SEARCH.
  - out_ready while out_valid=0 has no effect.
- DONE: busy=0, done=1. FAIL: busy=0, fail=1. Both are terminal until start or rst. cand holds its last value.
- No deduplication: repeated satisfying vectors are delivered as-is.
- Counters:
  - tries_used saturates at 2^32-1.
  - The sample count is 16 bits and wraps only in unlimited mode; that wrap is harmless.

Decomposition:
- Package sat_gen_pkg holds:
  - VEC_W, RNG_W and FILL_CYC;
  - per-variable width and offset localparams (VAR0_OFF..VAR9_OFF);
  - the seed constant K;
  - the state enum {IDLE, FILL, SEARCH, HOLD, DONE, FAIL};
  - an xorshift64 step function.
- One sub-module, sat_rng64: holds the 64-bit state with load, seed and advance inputs and a next-state output. The FSM, counters and output registers stay in sat_sample_gen.

Test Plan:
- sat_in tied 1, num_samples=3, out_ready=1, start at cycle 0. Expected: FILL over cycles 1-3; out_valid high at cycles 5, 7 and 9; done=1 at cycle 10; tries_used=3; busy=0.
- sat_in tied 0, max_tries=100. Expected: fail=1, tries_used=100, out_valid never asserted, done=0.
- sat_in tied 1, out_ready held 0 for 10 cycles. Expected: out_valid, out_data, cand and tries_used stable for all 10 cycles; a single accept on release.
- Two runs with seed=0 and seed=64'h9E3779B97F4A7C15. Expected: identical cand sequences cycle for cycle. A re-run with the same seed reproduces the identical out_data stream.
- rst asserted during HOLD with out_valid=1. Expected: the next cycle has out_valid=0, busy=0, state IDLE; a start issued during busy before the reset had no effect.
- 10-variable constraint checker attached, num_samples=8, random out_ready. Expected: each delivered out_data, re-applied to the checker, gives sat=1; tries_used >= 8.

Source files
------------

// File: rtl/sat_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sat_gen_pkg
// Brief    : Shared widths, variable layout, RNG seed constant, FSM states
//            and the xorshift64 step for the random SAT sample generator.
// Revision : 1.0 - initial release
// ============================================================================
package sat_gen_pkg;

    localparam int VEC_W    = 185;
    localparam int RNG_W    = 64;
    localparam int FILL_CYC = (VEC_W + RNG_W - 1) / RNG_W;

    localparam int VAR0_W = 16;
    localparam int VAR1_W = 22;
    localparam int VAR2_W = 4;
    localparam int VAR3_W = 28;
    localparam int VAR4_W = 19;
    localparam int VAR5_W = 18;
    localparam int VAR6_W = 19;
    localparam int VAR7_W = 14;
    localparam int VAR8_W = 16;
    localparam int VAR9_W = 29;

    // var_0 occupies the LSBs; each later variable sits directly above the last
    localparam int VAR0_OFF = 0;
    localparam int VAR1_OFF = VAR0_OFF + VAR0_W;
    localparam int VAR2_OFF = VAR1_OFF + VAR1_W;
    localparam int VAR3_OFF = VAR2_OFF + VAR2_W;
    localparam int VAR4_OFF = VAR3_OFF + VAR3_W;
    localparam int VAR5_OFF = VAR4_OFF + VAR4_W;
    localparam int VAR6_OFF = VAR5_OFF + VAR5_W;
    localparam int VAR7_OFF = VAR6_OFF + VAR6_W;
    localparam int VAR8_OFF = VAR7_OFF + VAR7_W;
    localparam int VAR9_OFF = VAR8_OFF + VAR8_W;

    localparam logic [RNG_W-1:0] K = 64'h9E3779B97F4A7C15;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        SEARCH = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4,
        FAIL   = 3'd5
    } state_t;

    function automatic logic [RNG_W-1:0] xorshift64(input logic [RNG_W-1:0] s);
        logic [RNG_W-1:0] x;
        x = s ^ (s << 13);
        x = x ^ (x >> 7);
        x = x ^ (x << 17);
        return x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_rng64.sv
`default_nettype none
// ============================================================================
// Module   : sat_rng64
// Brief    : 64-bit xorshift state register with seed load and advance.
// Revision : 1.0 - initial release
// ============================================================================
module sat_rng64
    import sat_gen_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [RNG_W-1:0] i_seed,
    input  logic             i_advance,
    output logic [RNG_W-1:0] o_next
);

    logic [RNG_W-1:0] r_state;

    // A zero seed would lock xorshift at zero forever, so it maps onto K
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= K;
        end else if (i_load) begin
            r_state <= (i_seed == '0) ? K : i_seed;
        end else if (i_advance) begin
            r_state <= o_next;
        end
    end

    assign o_next = xorshift64(r_state);

endmodule
`default_nettype wire

// File: rtl/sat_sample_gen.sv
`default_nettype none
// ============================================================================
// Module   : sat_sample_gen
// Brief    : Random candidate producer for a combinational constraint checker;
//            forwards satisfying vectors over valid/ready with try/sample budgets.
// Revision : 1.0 - initial release
// ============================================================================
module sat_sample_gen
    import sat_gen_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [63:0]      seed,
    input  logic [31:0]      max_tries,
    input  logic [15:0]      num_samples,
    output logic [VEC_W-1:0] cand,
    input  logic             sat_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VEC_W-1:0] out_data,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [31:0]      tries_used
);

    localparam int FILL_CNT_W = $clog2(FILL_CYC);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [FILL_CNT_W-1:0]   r_fill_cnt;
    logic [31:0]             r_max_tries;
    logic [15:0]             r_num_samples;
    logic [15:0]             r_sample_cnt;
    logic [31:0]             r_tries;
    logic [VEC_W-1:0]        r_cand;
    logic [VEC_W-1:0]        r_out_data;
    logic                    r_out_valid;

    logic                    w_start_ok;
    logic                    w_advance;
    logic                    w_fill_last;
    logic                    w_budget_hit;
    logic                    w_accept;
    logic                    w_quota_met;
    logic [RNG_W-1:0]        w_rng_next;

    assign w_start_ok   = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == FAIL));
    assign w_advance    = (r_state == FILL) || (r_state == SEARCH);
    assign w_fill_last  = (r_fill_cnt == FILL_CNT_W'(FILL_CYC - 1));
    // ">=" so a budget that ran out on a satisfying cycle still trips on the next check
    assign w_budget_hit = (r_max_tries != 32'd0) &&
                          (({1'b0, r_tries} + 33'd1) >= {1'b0, r_max_tries});
    assign w_accept     = r_out_valid && out_ready;
    assign w_quota_met  = (r_num_samples != 16'd0) && (r_sample_cnt == r_num_samples);

    sat_rng64 u_rng (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_start_ok),
        .i_seed    (seed),
        .i_advance (w_advance),
        .o_next    (w_rng_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    w_state_next = FILL;
                end
            end
            FILL: begin
                if (w_fill_last) begin
                    w_state_next = SEARCH;
                end
            end
            SEARCH: begin
                if (sat_in) begin
                    w_state_next = HOLD;
                end else if (w_budget_hit) begin
                    w_state_next = FAIL;
                end
            end
            HOLD: begin
                if (w_accept) begin
                    w_state_next = w_quota_met ? DONE : SEARCH;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_cnt    <= '0;
            r_max_tries   <= 32'd0;
            r_num_samples <= 16'd0;
            r_sample_cnt  <= 16'd0;
            r_tries       <= 32'd0;
            r_cand        <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_fill_cnt    <= '0;
                r_max_tries   <= max_tries;
                r_num_samples <= num_samples;
                r_sample_cnt  <= 16'd0;
                r_tries       <= 32'd0;
                r_cand        <= '0;
            end
            if (r_state == FILL) begin
                r_fill_cnt <= r_fill_cnt + FILL_CNT_W'(1);
            end
            if (w_advance) begin
                r_cand <= {r_cand[VEC_W-RNG_W-1:0], w_rng_next};
            end
            if (r_state == SEARCH) begin
                if (r_tries != 32'hFFFF_FFFF) begin
                    r_tries <= r_tries + 32'd1;
                end
                // Capture the vector the checker just judged, not the shifted one
                if (sat_in) begin
                    r_out_data   <= r_cand;
                    r_out_valid  <= 1'b1;
                    r_sample_cnt <= r_sample_cnt + 16'd1;
                end
            end
            if ((r_state == HOLD) && w_accept) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign cand       = r_cand;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign tries_used = r_tries;
    assign busy       = (r_state == FILL) || (r_state == SEARCH) || (r_state == HOLD);
    assign done       = (r_state == DONE);
    assign fail       = (r_state == FAIL);

endmodule
`default_nettype wire
